ring_decoder: RTL and testbench

- Receive-side companion to the team's one-hot ring counter.
- Samples a one-hot ring word and decodes it to a binary index.
- Checks that successive samples follow the rotate-left ring sequence: 0001→0010→0100→1000→0001.
- Acquires and reports lock, flags illegal words and sequence breaks, counts errors, and pulses on every wrap.

---
 rtl/ring_decoder.sv | 167 ++++++++++++++++
 tb/tb_ring_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ring_decoder
// Brief   : One-hot ring word decoder and rotate-left sequence lock checker.
// Revision: 1.0  initial release
// ============================================================================
module ring_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_en,
    input  logic [WIDTH-1:0]           q_in,
    output logic [$clog2(WIDTH)-1:0]   idx,
    output logic                       idx_valid,
    output logic                       locked,
    output logic                       seq_err,
    output logic                       illegal,
    output logic                       wrap,
    output logic [CNT_W-1:0]           err_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int GC_W  = $clog2(LOCK_LEN + 1);
    localparam logic [GC_W-1:0]  c_LOCK_LEN = GC_W'(LOCK_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   prev_q,      prev_d;
    logic [GC_W-1:0]    good_cnt_q,  good_cnt_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               idx_valid_q, idx_valid_d;
    logic               seq_err_q,   seq_err_d;
    logic               illegal_q,   illegal_d;
    logic               wrap_q,      wrap_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;

    logic               w_legal;
    logic               w_ok;
    logic [WIDTH-1:0]   w_expected;
    logic [IDX_W-1:0]   w_idx;
    logic [GC_W-1:0]    w_good_inc;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_legal    = (q_in != '0) && ((q_in & (q_in - WIDTH'(1))) == '0);
    assign w_expected = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    assign w_ok       = w_legal && (q_in == w_expected);
    assign w_good_inc = good_cnt_q + GC_W'(1);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_in[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        idx_d       = idx_q;
        idx_valid_d = idx_valid_q;
        seq_err_d   = 1'b0;
        illegal_d   = 1'b0;
        wrap_d      = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (sample_en) begin
            illegal_d   = !w_legal;
            idx_valid_d = w_legal;
            if (w_legal) begin
                idx_d  = w_idx;
                prev_d = q_in;
            end

            case (state_q)
                S_HUNT: begin
                    if (w_legal) begin
                        state_d    = S_TRACK;
                        good_cnt_d = '0;
                    end
                end
                S_TRACK: begin
                    if (w_ok) begin
                        wrap_d = prev_q[WIDTH-1] && q_in[0];
                        if (w_good_inc == c_LOCK_LEN) begin
                            state_d    = S_LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = w_good_inc;
                        end
                    end else if (w_legal) begin
                        seq_err_d  = 1'b1;
                        good_cnt_d = '0;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
                S_LOCKED: begin
                    if (w_ok) begin
                        wrap_d = prev_q[WIDTH-1] && q_in[0];
                    end else if (w_legal) begin
                        seq_err_d  = 1'b1;
                        state_d    = S_TRACK;
                        good_cnt_d = '0;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
                default: begin
                    state_d    = S_HUNT;
                    good_cnt_d = '0;
                end
            endcase

            if (seq_err_d && (err_cnt_q != c_CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HUNT;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            illegal_q   <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            seq_err_q   <= seq_err_d;
            illegal_q   <= illegal_d;
            wrap_q      <= wrap_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign idx       = idx_q;
    assign idx_valid = idx_valid_q;
    assign locked    = (state_q == S_LOCKED);
    assign seq_err   = seq_err_q;
    assign illegal   = illegal_q;
    assign wrap      = wrap_q;
    assign err_count = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ring_decoder
// Brief   : Directed self-checking bench for ring_decoder (WIDTH=4, CNT_W=2).
// Revision: 1.0  initial release
// ============================================================================
module tb_ring_decoder;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic [3:0] q_in;
    logic [1:0] idx;
    logic       idx_valid;
    logic       locked;
    logic       seq_err;
    logic       illegal;
    logic       wrap;
    logic [1:0] err_count;

    int n_cmp;
    int n_err;

    ring_decoder #(
        .WIDTH    (4),
        .LOCK_LEN (4),
        .CNT_W    (2)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .q_in      (q_in),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .seq_err   (seq_err),
        .illegal   (illegal),
        .wrap      (wrap),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one sample across one rising edge, then settle past the edge.
    task automatic t_step(input logic rst_n, input logic en, input logic [3:0] q);
        @(negedge clk);
        reset     = rst_n;
        sample_en = en;
        q_in      = q;
        @(posedge clk);
        #1;
    endtask

    task automatic t_expect(input string tag, input logic [1:0] e_idx, input logic e_val,
                            input logic e_lock, input logic e_seq, input logic e_ill,
                            input logic e_wrap, input logic [1:0] e_err);
        t_check({tag, ".idx"},       32'(idx),       32'(e_idx));
        t_check({tag, ".idx_valid"}, 32'(idx_valid), 32'(e_val));
        t_check({tag, ".locked"},    32'(locked),    32'(e_lock));
        t_check({tag, ".seq_err"},   32'(seq_err),   32'(e_seq));
        t_check({tag, ".illegal"},   32'(illegal),   32'(e_ill));
        t_check({tag, ".wrap"},      32'(wrap),      32'(e_wrap));
        t_check({tag, ".err_count"}, 32'(err_count), 32'(e_err));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        sample_en = 1'b1;
        q_in      = 4'b1111;

        // Reset overrides an enabled illegal word
        t_step(1'b0, 1'b1, 4'b1111);
        t_step(1'b0, 1'b1, 4'b1111);
        t_expect("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Zero word in HUNT: illegal but never a sequence error
        t_step(1'b1, 1'b1, 4'b0000);
        t_expect("hunt0", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

        // Acquire lock
        t_step(1'b1, 1'b1, 4'b0001); t_expect("acq0", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("acq1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        t_step(1'b1, 1'b1, 4'b0100); t_expect("acq2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        t_step(1'b1, 1'b1, 4'b1000); t_expect("acq3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        t_step(1'b1, 1'b1, 4'b0001); t_expect("acq4", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("acq5", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Illegal word while locked drops to HUNT
        t_step(1'b1, 1'b1, 4'b0011); t_expect("ill",  2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        t_step(1'b1, 1'b1, 4'b0100); t_expect("ill1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);

        // Relock from TRACK (prev=0100), then walk round to 0010
        t_step(1'b1, 1'b1, 4'b1000); t_expect("rl0", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        t_step(1'b1, 1'b1, 4'b0001); t_expect("rl1", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("rl2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        t_step(1'b1, 1'b1, 4'b0100); t_expect("rl3", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        t_step(1'b1, 1'b1, 4'b1000); t_expect("rl4", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        t_step(1'b1, 1'b1, 4'b0001); t_expect("rl5", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("rl6", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        // Skip while locked: legal but out of order
        t_step(1'b1, 1'b1, 4'b1000); t_expect("skip",  2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        t_step(1'b1, 1'b1, 4'b0001); t_expect("skip1", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("skip2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        t_step(1'b1, 1'b1, 4'b0100); t_expect("skip3", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        t_step(1'b1, 1'b1, 4'b1000); t_expect("skip4", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Enable gating while locked at 0100
        t_step(1'b1, 1'b1, 4'b0001); t_expect("gt0", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("gt1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        t_step(1'b1, 1'b1, 4'b0100); t_expect("gt2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            t_step(1'b1, 1'b0, 4'b1111);
            t_expect("gate", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
        end
        t_step(1'b1, 1'b1, 4'b1000); t_expect("gt3", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Repeated word is a sequence error; counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            t_step(1'b1, 1'b1, 4'b1000);
            t_expect("sat", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        end
        t_step(1'b1, 1'b1, 4'b0001); t_expect("sl0", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("sl1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        t_step(1'b1, 1'b1, 4'b0100); t_expect("sl2", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        t_step(1'b1, 1'b1, 4'b1000); t_expect("sl3", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);

        // Reset mid-operation while locked
        t_step(1'b0, 1'b1, 4'b0001); t_expect("rst2", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        // prev was cleared, so 0010 is only an acquisition from HUNT
        t_step(1'b1, 1'b1, 4'b0010); t_expect("post0", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        t_step(1'b1, 1'b1, 4'b0010); t_expect("post1", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
